// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD controller:
// register map, STATUS bit layout, FSM states and the FIFO entry format.
package lcd_pkg;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_BUSY = 7;
  localparam int STAT_FULL = 6;
  localparam int STAT_OVF  = 5;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_t;

  // "byte" is a keyword, so the payload field is called data
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  function automatic logic is_long_exec(input lcd_entry_t e);
    return !e.rs && (e.data == CMD_CLEAR || e.data == CMD_HOME || e.data == CMD_HOME_ALT);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO of LCD entries; pushes to a full FIFO are dropped and
// pops from an empty FIFO are ignored.
module lcd_fifo
  import lcd_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  lcd_entry_t    push_entry,
  input  logic          pop,
  output lcd_entry_t    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  lcd_entry_t    mem_q [DEPTH];
  lcd_entry_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lcd_controller.sv
// Memory-mapped character LCD controller: CPU writes are queued in a FIFO and
// an FSM replays them on the LCD pins with setup/enable/hold/exec timing.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH       = 8,
  parameter int POWERUP_CYCLES   = 2_500_000,
  parameter int SETUP_CYCLES     = 2,
  parameter int EN_CYCLES        = 12,
  parameter int HOLD_CYCLES      = 2,
  parameter int EXEC_CYCLES      = 2_000,
  parameter int LONG_EXEC_CYCLES = 82_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       chip_select,
  input  logic       wrt_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int MAX_CYC = max2(max2(max2(POWERUP_CYCLES, SETUP_CYCLES), max2(EN_CYCLES, HOLD_CYCLES)),
                                max2(EXEC_CYCLES, LONG_EXEC_CYCLES));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int FCW     = $clog2(FIFO_DEPTH + 1);

  lcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lcd_en_q, lcd_en_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       data_out_q, data_out_d;

  logic             push, pop, fifo_full, fifo_empty;
  lcd_entry_t       push_entry, head, cur_entry;
  logic [FCW-1:0]   fifo_count;
  logic             cnt_zero, wr_hit, rd_hit;
  logic [3:0]       cnt_sat;
  logic [7:0]       status_byte;

  lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign cnt_zero  = (cnt_q == '0);
  assign cur_entry = '{rs: lcd_rs_q, data: lcd_data_q};
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign lcd_en    = lcd_en_q;
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;
  assign data_out  = data_out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_POWERUP;
      cnt_q      <= CNT_W'(POWERUP_CYCLES - 1);
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
      ovf_q      <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lcd_en_q   <= lcd_en_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
    end
  end

  // One shared down-counter times every state; each transition reloads it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    pop     = 1'b0;
    case (state_q)
      ST_POWERUP: if (cnt_zero) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(EN_CYCLES - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_EXEC;
          cnt_d   = is_long_exec(cur_entry) ? CNT_W'(LONG_EXEC_CYCLES - 1) : CNT_W'(EXEC_CYCLES - 1);
        end
      end
      ST_EXEC:  if (cnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RS/DATA latch only on the pop so they stay stable for the whole transfer
  always_comb begin
    lcd_en_d   = (state_d == ST_PULSE);
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    if (pop) begin
      lcd_rs_d   = head.rs;
      lcd_data_d = head.data;
    end
  end

  assign cnt_sat = (int'(fifo_count) > 15) ? 4'hF : 4'(fifo_count);

  always_comb begin
    status_byte            = 8'h00;
    status_byte[STAT_BUSY] = busy;
    status_byte[STAT_FULL] = fifo_full;
    status_byte[STAT_OVF]  = ovf_q;
    status_byte[3:0]       = cnt_sat;
  end

  // A dropped push wins over a same-cycle STATUS read clearing overflow
  always_comb begin
    wr_hit     = chip_select && wrt_en;
    rd_hit     = chip_select && !wrt_en;
    push       = wr_hit && (address == REG_CMD || address == REG_DATA);
    push_entry = '{rs: (address == REG_DATA), data: data_in};
    ovf_d      = ovf_q;
    if (rd_hit && address == REG_STATUS) ovf_d = 1'b0;
    if (push && fifo_full) ovf_d = 1'b1;
    data_out_d = data_out_q;
    if (rd_hit) begin
      data_out_d = (address == REG_STATUS) ? status_byte : 8'h00;
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Self-checking bench for lcd_controller: a pin monitor records every EN pulse
// and a transfer-level model predicts pulse order, spacing and STATUS contents.
module tb_lcd_controller;

  localparam int DEPTH = 8;
  localparam int PWR   = 10;
  localparam int SETUP = 2;
  localparam int ENW   = 3;
  localparam int HOLD  = 2;
  localparam int EXEC  = 5;
  localparam int LONG  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] address = 2'd0;
  logic       chip_select = 1'b0;
  logic       wrt_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       lcd_en, lcd_rw, lcd_rs, busy;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_controller #(
    .FIFO_DEPTH(DEPTH), .POWERUP_CYCLES(PWR), .SETUP_CYCLES(SETUP), .EN_CYCLES(ENW),
    .HOLD_CYCLES(HOLD), .EXEC_CYCLES(EXEC), .LONG_EXEC_CYCLES(LONG)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chip_select(chip_select), .wrt_en(wrt_en),
    .data_in(data_in), .data_out(data_out), .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs),
    .lcd_data(lcd_data), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: every EN pulse becomes one record
  typedef struct {
    int         rise;
    int         fall;
    logic       rs;
    logic [7:0] data;
    logic       rs_f;
    logic [7:0] data_f;
  } pulse_t;

  pulse_t pulses[$];
  pulse_t cur;
  logic   en_prev = 1'b0;
  logic   busy_prev = 1'b0;
  int     busy_fall_cyc = -1;
  bit     rw_high = 1'b0;

  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_high = 1'b1;
    if (lcd_en === 1'b1 && en_prev === 1'b0) begin
      cur.rise = cyc;
      cur.rs   = lcd_rs;
      cur.data = lcd_data;
    end
    if (lcd_en === 1'b0 && en_prev === 1'b1) begin
      cur.fall   = cyc;
      cur.rs_f   = lcd_rs;
      cur.data_f = lcd_data;
      pulses.push_back(cur);
    end
    if (busy === 1'b0 && busy_prev === 1'b1) busy_fall_cyc = cyc;
    en_prev   = lcd_en;
    busy_prev = busy;
  end

  // Transfer-level reference model
  typedef struct {
    logic       rs;
    logic [7:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   model_level = 0;
  bit   model_ovf = 1'b0;

  function automatic int exec_of(input ent_t e);
    return (!e.rs && e.data >= 8'h01 && e.data <= 8'h03) ? LONG : EXEC;
  endfunction

  function automatic logic [7:0] model_status(input bit b, input int level, input bit ovf);
    logic [3:0] c;
    c = (level > 15) ? 4'hF : 4'(level);
    return {b, (level == DEPTH), ovf, 1'b0, c};
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] r;
    if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(1, 3));
    else r = 8'($urandom);
    return r;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    ent_t e;
    chip_select = 1'b1; wrt_en = 1'b1; address = a; data_in = d;
    if (a == 2'd0 || a == 2'd1) begin
      e.rs = (a == 2'd1); e.data = d;
      if (model_level < DEPTH) begin exp_q.push_back(e); model_level++; end
      else model_ovf = 1'b1;
    end
    @(negedge clk);
    chip_select = 1'b0; wrt_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chip_select = 1'b1; wrt_en = 1'b0; address = a;
    @(negedge clk);
    chip_select = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete(); model_level = 0; model_ovf = 1'b0;
    pulses.delete(); busy_fall_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; chip_select = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; t0 = cyc;
    model_clear();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (lcd_en !== 1'b0) $display("[TB] FAIL reset_lcd_en got %b want 0", lcd_en); else n_pass++;
    n_checks++; if (lcd_rs !== 1'b0) $display("[TB] FAIL reset_lcd_rs got %b want 0", lcd_rs); else n_pass++;
    n_checks++; if (lcd_data !== 8'h00) $display("[TB] FAIL reset_lcd_data got %h want 00", lcd_data); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("[TB] FAIL reset_data_out got %h want 00", data_out); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy got %b want 1", busy); else n_pass++;
  endtask

  task automatic test_powerup();
    bit ok;
    do_reset();
    bus_write(2'd0, 8'h38);
    wait_idle(200, ok);
    n_checks++; if (!ok) $display("[TB] FAIL powerup_idle busy got %b want 0 within budget", busy); else n_pass++;
    n_checks++; if (pulses.size() != 1) $display("[TB] FAIL powerup_pulse_count got %0d want 1", pulses.size()); else n_pass++;
    if (pulses.size() > 0) begin
      n_checks++; if (pulses[0].rise - t0 != PWR + 1 + SETUP)
        $display("[TB] FAIL powerup_first_rise got %0d want %0d", pulses[0].rise - t0, PWR + 1 + SETUP); else n_pass++;
      n_checks++; if (pulses[0].fall - pulses[0].rise != ENW)
        $display("[TB] FAIL powerup_en_width got %0d want %0d", pulses[0].fall - pulses[0].rise, ENW); else n_pass++;
      n_checks++; if ({pulses[0].rs, pulses[0].data} !== {1'b0, 8'h38})
        $display("[TB] FAIL powerup_entry got rs=%b data=%h want rs=0 data=38", pulses[0].rs, pulses[0].data); else n_pass++;
      n_checks++; if ({pulses[0].rs_f, pulses[0].data_f} !== {1'b0, 8'h38})
        $display("[TB] FAIL powerup_hold got rs=%b data=%h want rs=0 data=38", pulses[0].rs_f, pulses[0].data_f); else n_pass++;
      n_checks++; if (busy_fall_cyc - pulses[0].fall != HOLD + EXEC)
        $display("[TB] FAIL powerup_busy_drop got %0d want %0d", busy_fall_cyc - pulses[0].fall, HOLD + EXEC); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int tw;
    model_clear();
    tw = cyc;
    bus_write(2'd1, 8'h41);
    bus_write(2'd1, 8'h42);
    wait_idle(300, ok);
    n_checks++; if (!ok) $display("[TB] FAIL b2b_idle busy got %b want 0 within budget", busy); else n_pass++;
    n_checks++; if (pulses.size() != 2) $display("[TB] FAIL b2b_pulse_count got %0d want 2", pulses.size()); else n_pass++;
    if (pulses.size() == 2) begin
      n_checks++; if ({pulses[0].rs, pulses[0].data} !== {1'b1, 8'h41})
        $display("[TB] FAIL b2b_first got rs=%b data=%h want rs=1 data=41", pulses[0].rs, pulses[0].data); else n_pass++;
      n_checks++; if ({pulses[1].rs, pulses[1].data} !== {1'b1, 8'h42})
        $display("[TB] FAIL b2b_second got rs=%b data=%h want rs=1 data=42", pulses[1].rs, pulses[1].data); else n_pass++;
      n_checks++; if (pulses[0].rise - tw != SETUP + 2)
        $display("[TB] FAIL b2b_first_latency got %0d want %0d", pulses[0].rise - tw, SETUP + 2); else n_pass++;
      n_checks++; if (pulses[1].rise - pulses[0].fall != HOLD + EXEC + 1 + SETUP)
        $display("[TB] FAIL b2b_gap got %0d want %0d", pulses[1].rise - pulses[0].fall, HOLD + EXEC + 1 + SETUP); else n_pass++;
    end
  endtask

  task automatic test_long_exec();
    bit ok;
    logic [7:0] codes [5] = '{8'h01, 8'h02, 8'h03, 8'h0C, 8'h01};
    for (int i = 0; i < 5; i++) begin
      model_clear();
      bus_write((i == 4) ? 2'd1 : 2'd0, codes[i]);
      wait_idle(200, ok);
      n_checks++; if (!ok || pulses.size() != 1)
        $display("[TB] FAIL exec_case%0d pulses got %0d want 1 (idle=%b)", i, pulses.size(), ok); else n_pass++;
      if (pulses.size() == 1) begin
        n_checks++; if (busy_fall_cyc - pulses[0].fall != HOLD + exec_of(exp_q[0]))
          $display("[TB] FAIL exec_len_case%0d got %0d want %0d", i, busy_fall_cyc - pulses[0].fall, HOLD + exec_of(exp_q[0]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reserved();
    bit ok;
    logic [7:0] want;
    do_reset();
    bus_write(2'd0, 8'h80);
    bus_write(2'd3, 8'h55);
    want = model_status(1'b1, model_level, model_ovf);
    bus_read(2'd2);
    n_checks++; if (data_out !== want) $display("[TB] FAIL rsvd_write_status got %h want %h", data_out, want); else n_pass++;
    @(negedge clk);
    n_checks++; if (data_out !== want) $display("[TB] FAIL data_out_hold got %h want %h", data_out, want); else n_pass++;
    bus_read(2'd3);
    n_checks++; if (data_out !== 8'h00) $display("[TB] FAIL rsvd_read got %h want 00", data_out); else n_pass++;
    wait_idle(200, ok);
    n_checks++; if (!ok || pulses.size() != 1 || pulses[0].data !== 8'h80)
      $display("[TB] FAIL rsvd_pulses got %0d pulses want 1 with data 80", pulses.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] want1, want2, want3;
    logic [7:0] got1, got2;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) bus_write(2'($urandom_range(0, 1)), rand_byte());
    want1 = model_status(1'b1, model_level, model_ovf);
    bus_read(2'd2);
    got1 = data_out;
    model_ovf = 1'b0;
    want2 = model_status(1'b1, model_level, model_ovf);
    bus_read(2'd2);
    got2 = data_out;
    n_checks++; if (got1 !== want1) $display("[TB] FAIL ovf_status1 got %h want %h", got1, want1); else n_pass++;
    n_checks++; if (got2 !== want2) $display("[TB] FAIL ovf_status2 got %h want %h", got2, want2); else n_pass++;
    wait_idle(1000, ok);
    n_checks++; if (!ok) $display("[TB] FAIL ovf_idle busy got %b want 0 within budget", busy); else n_pass++;
    n_checks++; if (pulses.size() != exp_q.size())
      $display("[TB] FAIL ovf_pulse_count got %0d want %0d", pulses.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < pulses.size() && k < exp_q.size(); k++) begin
      n_checks++; if ({pulses[k].rs, pulses[k].data} !== {exp_q[k].rs, exp_q[k].data})
        $display("[TB] FAIL ovf_entry%0d got rs=%b data=%h want rs=%b data=%h", k, pulses[k].rs, pulses[k].data,
                 exp_q[k].rs, exp_q[k].data); else n_pass++;
    end
    want3 = model_status(1'b0, 0, 1'b0);
    bus_read(2'd2);
    n_checks++; if (data_out !== want3) $display("[TB] FAIL ovf_status_drained got %h want %h", data_out, want3); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    bit found;
    int npulses;
    do_reset();
    for (int i = 0; i < 3; i++) bus_write(2'd1, rand_byte());
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_en === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) $display("[TB] FAIL midrst_pulse_seen got 0 want 1"); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (lcd_en !== 1'b0) $display("[TB] FAIL midrst_en_async got %b want 0", lcd_en); else n_pass++;
    n_checks++; if ({lcd_rs, lcd_data} !== 9'h000) $display("[TB] FAIL midrst_pins got rs=%b data=%h want 0/00", lcd_rs, lcd_data); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1; t0 = cyc;
    #1;
    model_clear();
    npulses = pulses.size();
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL midrst_busy got %b want 1", busy); else n_pass++;
    @(negedge clk);
    bus_read(2'd2);
    n_checks++; if (data_out !== model_status(1'b1, 0, 1'b0))
      $display("[TB] FAIL midrst_status got %h want %h", data_out, model_status(1'b1, 0, 1'b0)); else n_pass++;
    repeat (60) @(negedge clk);
    n_checks++; if (pulses.size() != npulses) $display("[TB] FAIL midrst_no_pulses got %0d want %0d", pulses.size(), npulses); else n_pass++;
    n_checks++; if (busy_fall_cyc - t0 != PWR) $display("[TB] FAIL midrst_busy_drop got %0d want %0d", busy_fall_cyc - t0, PWR); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int tw, n, last;
    for (int it = 0; it < 6; it++) begin
      model_clear();
      n  = $urandom_range(1, 6);
      tw = cyc;
      for (int k = 0; k < n; k++) bus_write(2'($urandom_range(0, 1)), rand_byte());
      wait_idle(600, ok);
      n_checks++; if (!ok || pulses.size() != exp_q.size())
        $display("[TB] FAIL rnd%0d_count got %0d want %0d (idle=%b)", it, pulses.size(), exp_q.size(), ok); else n_pass++;
      for (int k = 0; k < pulses.size() && k < exp_q.size(); k++) begin
        n_checks++; if ({pulses[k].rs, pulses[k].data, pulses[k].rs_f, pulses[k].data_f} !==
                        {exp_q[k].rs, exp_q[k].data, exp_q[k].rs, exp_q[k].data})
          $display("[TB] FAIL rnd%0d_entry%0d got rs=%b data=%h/%h want rs=%b data=%h", it, k, pulses[k].rs,
                   pulses[k].data, pulses[k].data_f, exp_q[k].rs, exp_q[k].data); else n_pass++;
        n_checks++; if (pulses[k].fall - pulses[k].rise != ENW)
          $display("[TB] FAIL rnd%0d_width%0d got %0d want %0d", it, k, pulses[k].fall - pulses[k].rise, ENW); else n_pass++;
        if (k == 0) begin
          n_checks++; if (pulses[0].rise - tw != SETUP + 2)
            $display("[TB] FAIL rnd%0d_latency got %0d want %0d", it, pulses[0].rise - tw, SETUP + 2); else n_pass++;
        end else begin
          n_checks++; if (pulses[k].rise - pulses[k-1].fall != HOLD + exec_of(exp_q[k-1]) + 1 + SETUP)
            $display("[TB] FAIL rnd%0d_gap%0d got %0d want %0d", it, k, pulses[k].rise - pulses[k-1].fall,
                     HOLD + exec_of(exp_q[k-1]) + 1 + SETUP); else n_pass++;
        end
      end
      if (pulses.size() > 0 && pulses.size() == exp_q.size()) begin
        last = pulses.size() - 1;
        n_checks++; if (busy_fall_cyc - pulses[last].fall != HOLD + exec_of(exp_q[last]))
          $display("[TB] FAIL rnd%0d_busy_drop got %0d want %0d", it, busy_fall_cyc - pulses[last].fall,
                   HOLD + exec_of(exp_q[last])); else n_pass++;
      end
    end
  endtask

  initial begin
    #3 reset = 1'b0;
    test_reset();
    test_powerup();
    test_back_to_back();
    test_long_exec();
    test_reserved();
    test_overflow();
    test_reset_mid_pulse();
    test_random();
    n_checks++; if (rw_high) $display("[TB] FAIL lcd_rw_constant got 1 want 0"); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
